// File: rtl/bft_leaf_packetizer.sv
// Transmit-side BFT leaf packetizer: ap_vld/ap_ack words in, one credit-gated packet out per word.
// Optional per-packet and stall counters are enabled with `define PACKETIZER_PKT_CNT_EN.
module bft_leaf_packetizer #(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int CREDIT_INIT   = 128,
    parameter int CTRL_PORT     = 0
) (
    input  logic                     clk_bft,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [NUM_LEAF_BITS-1:0] dest_leaf,
    input  logic [NUM_PORT_BITS-1:0] dest_port,
    input  logic [PAYLOAD_BITS-1:0]  din_user,
    input  logic                     vld_user,
    output logic                     ack_user,
    input  logic [PACKET_BITS-1:0]   din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]   dout_leaf_interface2bft,
    output logic [NUM_ADDR_BITS:0]   credit,
    output logic                     busy
`ifdef PACKETIZER_PKT_CNT_EN
    ,
    output logic [31:0]              pkt_cnt,
    output logic [31:0]              stall_cnt
`endif
);

    localparam int CREDIT_BITS = NUM_ADDR_BITS + 1;
    localparam int ADDR_LSB    = PAYLOAD_BITS;
    localparam int PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int VALID_BIT   = PACKET_BITS - 1;

    localparam logic [CREDIT_BITS+1:0] CREDIT_MAX = (CREDIT_BITS + 2)'(CREDIT_INIT);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WAIT_CREDIT
    } state_t;

    state_t                   state, state_next;
    logic [NUM_LEAF_BITS-1:0] leaf_q;
    logic [NUM_PORT_BITS-1:0] port_q;
    logic [NUM_ADDR_BITS-1:0] seq;
    logic                     accept;
    logic                     credit_hit;
    logic [CREDIT_BITS-1:0]   credit_inc;
    logic [CREDIT_BITS+1:0]   credit_sum;
    logic [CREDIT_BITS-1:0]   credit_next;
    logic                     unused_din;

    // Only valid packets addressed to the control port return credit; the rest are dropped.
    assign credit_hit = din_leaf_bft2interface[VALID_BIT] &&
                        (din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS] == NUM_PORT_BITS'(CTRL_PORT));
    assign credit_inc = credit_hit ? din_leaf_bft2interface[CREDIT_BITS-1:0] : '0;
    assign unused_din = ^{din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS],
                          din_leaf_bft2interface[PORT_LSB-1:CREDIT_BITS]};

    assign accept   = (state == RUN) && vld_user && enable && (credit != '0);
    assign ack_user = accept;
    assign busy     = (state != IDLE);

    // Widened sum: credit >= accept, so subtraction cannot underflow before clamping.
    assign credit_sum  = {2'b00, credit} + {2'b00, credit_inc} - {{(CREDIT_BITS + 1){1'b0}}, accept};
    assign credit_next = (credit_sum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_BITS-1:0]
                                                   : credit_sum[CREDIT_BITS-1:0];

    always_comb begin
        // NOTE: default first so every path assigns state_next and no latch is inferred.
        state_next = state;
        case (state)
            IDLE: begin
                if (enable) state_next = RUN;
            end
            RUN: begin
                if (!enable)                          state_next = IDLE;
                else if (accept && credit_next == '0) state_next = WAIT_CREDIT;
            end
            WAIT_CREDIT: begin
                // Leave on the returning credit itself so sending resumes the very next cycle.
                if (!enable)                 state_next = IDLE;
                else if (credit_next != '0)  state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments keep every register update on the same clock edge.
    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            state                   <= IDLE;
            credit                  <= CREDIT_BITS'(CREDIT_INIT);
            seq                     <= '0;
            leaf_q                  <= '0;
            port_q                  <= '0;
            dout_leaf_interface2bft <= '0;
        end else begin
            state  <= state_next;
            credit <= credit_next;
            if (state == IDLE) begin
                leaf_q <= dest_leaf;
                port_q <= dest_port;
            end
            if (accept) begin
                seq                     <= seq + 1'b1;
                dout_leaf_interface2bft <= {1'b1, leaf_q, port_q, seq, din_user};
            end else begin
                dout_leaf_interface2bft <= '0;
            end
        end
    end

`ifdef PACKETIZER_PKT_CNT_EN
    always_ff @(posedge clk_bft or posedge reset) begin
        if (reset) begin
            pkt_cnt   <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept) pkt_cnt <= pkt_cnt + 32'd1;
            if (state == WAIT_CREDIT && vld_user && stall_cnt != '1)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bft_leaf_packetizer.sv
// Directed self-checking bench for bft_leaf_packetizer: send, credit exhaustion/return,
// saturation, control-packet filtering, sequence wrap/persistence and async reset.
module tb_bft_leaf_packetizer;

    logic        clk_bft = 1'b0;
    logic        reset   = 1'b0;
    logic        enable  = 1'b0;
    logic [4:0]  dest_leaf = '0;
    logic [3:0]  dest_port = '0;
    logic [31:0] din_user  = '0;
    logic        vld_user  = 1'b0;
    logic        ack_user;
    logic [48:0] din_leaf_bft2interface = '0;
    logic [48:0] dout_leaf_interface2bft;
    logic [7:0]  credit;
    logic        busy;
`ifdef PACKETIZER_PKT_CNT_EN
    logic [31:0] pkt_cnt;
    logic [31:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int acks;

    bft_leaf_packetizer dut (
        .clk_bft                 (clk_bft),
        .reset                   (reset),
        .enable                  (enable),
        .dest_leaf               (dest_leaf),
        .dest_port               (dest_port),
        .din_user                (din_user),
        .vld_user                (vld_user),
        .ack_user                (ack_user),
        .din_leaf_bft2interface  (din_leaf_bft2interface),
        .dout_leaf_interface2bft (dout_leaf_interface2bft),
        .credit                  (credit),
        .busy                    (busy)
`ifdef PACKETIZER_PKT_CNT_EN
        ,
        .pkt_cnt                 (pkt_cnt),
        .stall_cnt               (stall_cnt)
`endif
    );

    always #5 clk_bft = ~clk_bft;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the rising edge: registered outputs are settled.
    task automatic tick();
        @(posedge clk_bft);
        #1;
    endtask

    function automatic logic [48:0] pkt(input logic [4:0] l, input logic [3:0] p,
                                        input logic [6:0] a, input logic [31:0] d);
        return {1'b1, l, p, a, d};
    endfunction

    function automatic logic [48:0] ctrl(input logic [7:0] n);
        return {1'b1, 5'd9, 4'd0, 7'd0, 24'd0, n};
    endfunction

    task automatic start_run(input logic [4:0] l, input logic [3:0] p);
        vld_user = 1'b0;
        reset = 1'b1;
        #2;
        reset = 1'b0;
        dest_leaf = l;
        dest_port = p;
        enable = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        reset = 1'b1;
        tick();
        check("rst_dout", dout_leaf_interface2bft, 49'd0);
        check("rst_ack", ack_user, 1'b0);
        check("rst_credit", credit, 8'd128);
        check("rst_busy", busy, 1'b0);
        reset = 1'b0;

        // Basic send: four back-to-back words, each emitted one cycle after its ack
        dest_leaf = 5'd3;
        dest_port = 4'd2;
        enable = 1'b1;
        tick();
        check("basic_busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            din_user = 32'hA0 + 32'(i);
            vld_user = 1'b1;
            #1;
            check("basic_ack", ack_user, 1'b1);
            tick();
            check("basic_pkt", dout_leaf_interface2bft, pkt(5'd3, 4'd2, 7'(i), 32'hA0 + 32'(i)));
        end
        vld_user = 1'b0;
        tick();
        check("basic_dout_clear", dout_leaf_interface2bft, 49'd0);
        check("basic_credit", credit, 8'd124);

        // Credit exhaustion from a fresh 128, also covering address 126,127 -> 0,1
        start_run(5'd9, 4'd3);
        acks = 0;
        vld_user = 1'b1;
        for (int c = 0; c < 130; c++) begin
            din_user = 32'(c);
            #1;
            if (ack_user) acks++;
            tick();
            if (c == 126) check("wrap_addr126", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd126, 32'd126));
            if (c == 127) check("wrap_addr127", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd127, 32'd127));
        end
        check("exhaust_acks", 64'(acks), 64'd128);
        check("exhaust_ack_low", ack_user, 1'b0);
        check("exhaust_credit", credit, 8'd0);
        check("exhaust_busy", busy, 1'b1);
        check("exhaust_dout", dout_leaf_interface2bft, 49'd0);

        din_leaf_bft2interface = ctrl(8'd64);
        #1;
        check("wait_ack_low", ack_user, 1'b0);
        tick();
        din_leaf_bft2interface = '0;
        check("return_credit", credit, 8'd64);
        acks = 0;
        for (int c = 0; c < 70; c++) begin
            din_user = 32'h1000 + 32'(c);
            #1;
            if (ack_user) acks++;
            if (c == 0) check("resume_ack", ack_user, 1'b1);
            tick();
            if (c == 0) check("wrap_addr0", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd0, 32'h1000));
            if (c == 1) check("wrap_addr1", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd1, 32'h1001));
        end
        check("resume_acks", 64'(acks), 64'd64);
        check("resume_credit", credit, 8'd0);

        // Simultaneous accept and return at credit=1
        vld_user = 1'b0;
        din_leaf_bft2interface = ctrl(8'd1);
        tick();
        din_leaf_bft2interface = '0;
        check("sim_credit1", credit, 8'd1);
        vld_user = 1'b1;
        din_user = 32'h55;
        din_leaf_bft2interface = ctrl(8'd64);
        #1;
        check("sim_ack", ack_user, 1'b1);
        tick();
        din_leaf_bft2interface = '0;
        check("sim_credit64", credit, 8'd64);
        check("sim_pkt", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd64, 32'h55));
        #1;
        check("sim_no_stall", ack_user, 1'b1);
        vld_user = 1'b0;
        tick();

        // Non-control packets leave credit unchanged
        din_leaf_bft2interface = {1'b1, 5'd9, 4'd5, 7'd0, 32'h40};
        tick();
        check("nonctrl_port5", credit, 8'd64);
        din_leaf_bft2interface = {1'b0, 5'd9, 4'd0, 7'd0, 32'h40};
        tick();
        check("nonctrl_invalid", credit, 8'd64);

        // Saturation
        din_leaf_bft2interface = ctrl(8'd36);
        tick();
        check("credit_100", credit, 8'd100);
        din_leaf_bft2interface = ctrl(8'd200);
        tick();
        din_leaf_bft2interface = '0;
        check("credit_sat", credit, 8'd128);

        // Dest changes outside IDLE are ignored; seq persists across an enable toggle
        dest_leaf = 5'd20;
        dest_port = 4'd7;
        vld_user = 1'b1;
        din_user = 32'h66;
        #1;
        check("persist_ack", ack_user, 1'b1);
        tick();
        vld_user = 1'b0;
        check("dest_ignored", dout_leaf_interface2bft, pkt(5'd9, 4'd3, 7'd65, 32'h66));
        enable = 1'b0;
        tick();
        check("disable_idle", busy, 1'b0);
        enable = 1'b1;
        tick();
        check("reenable_busy", busy, 1'b1);
        vld_user = 1'b1;
        din_user = 32'h77;
        #1;
        check("reenable_ack", ack_user, 1'b1);
        tick();
        check("seq_persist", dout_leaf_interface2bft, pkt(5'd20, 4'd7, 7'd66, 32'h77));

        // Asynchronous reset in the middle of a burst
        din_user = 32'hB0;
        #1;
        tick();
        check("burst_pkt", dout_leaf_interface2bft, pkt(5'd20, 4'd7, 7'd67, 32'hB0));
        #2;
        reset = 1'b1;
        #1;
        check("async_dout", dout_leaf_interface2bft, 49'd0);
        check("async_ack", ack_user, 1'b0);
        check("async_credit", credit, 8'd128);
        check("async_busy", busy, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_busy", busy, 1'b0);
        check("post_rst_ack", ack_user, 1'b0);
        tick();
        din_user = 32'hC0;
        #1;
        check("post_rst_ack_run", ack_user, 1'b1);
        tick();
        check("post_rst_seq0", dout_leaf_interface2bft, pkt(5'd20, 4'd7, 7'd0, 32'hC0));
        vld_user = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
